// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller for the raccoon/car game.
// Sequences IDLE -> COUNTDOWN -> PLAY -> HIT/LEVEL_UP -> GAME_OVER/WIN and
// owns the lives count and level number. All timing is in video frames.
// Optional build macro: ROUND_SEQ_LIFE_BONUS_EN awards one life (saturating
// at START_LIVES) on every LEVEL_UP -> COUNTDOWN transition.
// Handshake-free block: inputs are levels/pulses sampled every clock; every
// output is a flop, so a decision taken in cycle N is visible after edge N+1.
module round_sequencer #(
  parameter int START_LIVES      = 3,
  parameter int MAX_LEVEL        = 9,
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int HIT_FRAMES       = 60,
  parameter int GRACE_FRAMES     = 90,
  parameter int BLINK_FRAMES     = 8
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Abort,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic [2:0] o_State,
  output logic       o_Freeze,
  output logic       o_Respawn,
  output logic [3:0] o_Level,
  output logic [2:0] o_Lives,
  output logic       o_Blink,
  output logic       o_Game_Over,
  output logic       o_Win
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_HIT       = 3'd3,
    S_LEVEL_UP  = 3'd4,
    S_GAME_OVER = 3'd5,
    S_WIN       = 3'd6
  } state_t;

  // Frame counters compare against "last" values so a duration of N exits on
  // the tick that would bring the count to N.
  localparam logic [7:0] CD_LAST    = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] GRACE_LOAD = 8'(GRACE_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [2:0] START_L    = 3'(START_LIVES);
  localparam logic [3:0] MAX_L      = 4'(MAX_LEVEL);

  state_t     state, state_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [7:0] grace_cnt, grace_n;
  logic [7:0] blink_cnt, blink_cnt_n;
  logic [2:0] lives, lives_n;
  logic [3:0] level, level_n;
  logic       blink, blink_n;
  logic       respawn_n;
  logic       start_q;
  logic       start_edge;
  logic       blink_active;

  assign start_edge   = i_Start & ~start_q;
  // Sprite flashes while frozen after a hit and while invulnerable in PLAY.
  assign blink_active = (state == S_HIT) || ((state == S_PLAY) && (grace_cnt != 8'd0));

  // Next-state, counter and lives/level decisions; abort overrides everything.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    grace_n     = grace_cnt;
    blink_cnt_n = blink_cnt;
    blink_n     = blink;
    lives_n     = lives;
    level_n     = level;
    respawn_n   = 1'b0;

    case (state)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (start_edge) begin
          lives_n   = START_L;
          level_n   = 4'd0;
          respawn_n = 1'b1;
          state_n   = S_COUNTDOWN;
        end
      end
      S_COUNTDOWN: begin
        if (i_Frame_Tick) begin
          if (frame_cnt == CD_LAST) begin
            state_n = S_PLAY;
            grace_n = GRACE_LOAD;
          end else begin
            frame_cnt_n = frame_cnt + 8'd1;
          end
        end
      end
      S_PLAY: begin
        // Collision outranks goal; collisions are ignored while invulnerable.
        if (i_Collision && (grace_cnt == 8'd0)) begin
          state_n = S_HIT;
          if (lives != 3'd0) lives_n = lives - 3'd1;
        end else if (i_Goal) begin
          state_n = S_LEVEL_UP;
          level_n = level + 4'd1;
        end else if (i_Frame_Tick && (grace_cnt != 8'd0)) begin
          grace_n = grace_cnt - 8'd1;
        end
      end
      S_HIT: begin
        if (i_Frame_Tick) begin
          if (frame_cnt == HIT_LAST) begin
            if (lives == 3'd0) begin
              state_n = S_GAME_OVER;
            end else begin
              respawn_n = 1'b1;
              grace_n   = GRACE_LOAD;
              state_n   = S_PLAY;
            end
          end else begin
            frame_cnt_n = frame_cnt + 8'd1;
          end
        end
      end
      S_LEVEL_UP: begin
        if (i_Frame_Tick) begin
          if (frame_cnt == HIT_LAST) begin
            if (level == MAX_L) begin
              state_n = S_WIN;
            end else begin
              respawn_n = 1'b1;
              state_n   = S_COUNTDOWN;
`ifdef ROUND_SEQ_LIFE_BONUS_EN
              if (lives < START_L) lives_n = lives + 3'd1;
`else
              lives_n = lives;
`endif
            end
          end else begin
            frame_cnt_n = frame_cnt + 8'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (!blink_active) begin
      blink_n     = 1'b1;
      blink_cnt_n = 8'd0;
    end else if (i_Frame_Tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_n     = ~blink;
        blink_cnt_n = 8'd0;
      end else begin
        blink_cnt_n = blink_cnt + 8'd1;
      end
    end

    // Every state entry restarts frame timing and shows the sprite.
    if (state_n != state) begin
      frame_cnt_n = 8'd0;
      blink_n     = 1'b1;
      blink_cnt_n = 8'd0;
    end

    if (i_Abort) begin
      state_n     = S_IDLE;
      lives_n     = START_L;
      level_n     = 4'd0;
      frame_cnt_n = 8'd0;
      grace_n     = 8'd0;
      blink_cnt_n = 8'd0;
      blink_n     = 1'b1;
      respawn_n   = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= S_IDLE;
      frame_cnt   <= 8'd0;
      grace_cnt   <= 8'd0;
      blink_cnt   <= 8'd0;
      blink       <= 1'b1;
      lives       <= START_L;
      level       <= 4'd0;
      start_q     <= 1'b0;
      o_Freeze    <= 1'b1;
      o_Respawn   <= 1'b0;
      o_Game_Over <= 1'b0;
      o_Win       <= 1'b0;
    end else begin
      state       <= state_n;
      frame_cnt   <= frame_cnt_n;
      grace_cnt   <= grace_n;
      blink_cnt   <= blink_cnt_n;
      blink       <= blink_n;
      lives       <= lives_n;
      level       <= level_n;
      start_q     <= i_Start;
      o_Freeze    <= (state_n != S_PLAY);
      o_Respawn   <= respawn_n;
      o_Game_Over <= (state_n == S_GAME_OVER);
      o_Win       <= (state_n == S_WIN);
    end
  end

  assign o_State = state;
  assign o_Level = level;
  assign o_Lives = lives;
  assign o_Blink = blink;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed game scenarios followed by random play.
// A frame-based reference model predicts every change of the output tuple
// together with the cycle it must appear in; a monitor compares observed
// changes against that expected queue.
`timescale 1ns/1ps
module tb_round_sequencer;

  localparam int START_LIVES = 3;
  localparam int MAX_LEVEL   = 9;
  localparam int CD_FRAMES   = 120;
  localparam int HIT_FRAMES  = 60;
  localparam int GRACE       = 90;
  localparam int BLINK       = 8;

  localparam int M_IDLE = 0, M_CD = 1, M_PLAY = 2, M_HIT = 3, M_LU = 4, M_GO = 5, M_WIN = 6;

  localparam int TW = 15;
  localparam int W  = 32 + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tick = 1'b0, start = 1'b0, abort = 1'b0, collision = 1'b0, goal = 1'b0;
  logic [2:0] st;
  logic       freeze, respawn;
  logic [3:0] level;
  logic [2:0] lives;
  logic       blink, game_over, win;

  round_sequencer #(
    .START_LIVES(START_LIVES), .MAX_LEVEL(MAX_LEVEL), .COUNTDOWN_FRAMES(CD_FRAMES),
    .HIT_FRAMES(HIT_FRAMES), .GRACE_FRAMES(GRACE), .BLINK_FRAMES(BLINK)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Frame_Tick(tick), .i_Start(start),
    .i_Abort(abort), .i_Collision(collision), .i_Goal(goal),
    .o_State(st), .o_Freeze(freeze), .o_Respawn(respawn), .o_Level(level),
    .o_Lives(lives), .o_Blink(blink), .o_Game_Over(game_over), .o_Win(win)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tick_wait = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [TW-1:0] pack(input int s, input int fr, input int rs, input int lv,
                                         input int li, input int bl, input int go, input int wn);
    pack = {3'(s), 1'(fr), 1'(rs), 4'(lv), 3'(li), 1'(bl), 1'(go), 1'(wn)};
  endfunction

  // ---------------- reference model ----------------
  int m_state = M_IDLE, m_lives = START_LIVES, m_level = 0, m_frames = 0;
  int m_grace = 0, m_blink = 1, m_bticks = 0, m_respawn = 0, m_start_q = 0;
  logic [TW-1:0] m_prev = pack(M_IDLE, 1, 0, 0, START_LIVES, 1, 0, 0);
  logic [TW-1:0] m_now;

  function automatic logic [TW-1:0] model_tuple();
    model_tuple = pack(m_state, int'(m_state != M_PLAY), m_respawn, m_level, m_lives,
                       m_blink, int'(m_state == M_GO), int'(m_state == M_WIN));
  endfunction

  task automatic model_step();
    int  nxt;
    bit  edge_s, flashing;
    edge_s    = start && (m_start_q == 0);
    m_start_q = int'(start);
    m_respawn = 0;
    nxt       = m_state;
    flashing  = (m_state == M_HIT) || (m_state == M_PLAY && m_grace > 0);
    if (!flashing) begin
      m_blink = 1; m_bticks = 0;
    end else if (tick) begin
      m_bticks++;
      if (m_bticks == BLINK) begin m_blink = 1 - m_blink; m_bticks = 0; end
    end
    case (m_state)
      M_IDLE, M_GO, M_WIN:
        if (edge_s) begin m_lives = START_LIVES; m_level = 0; m_respawn = 1; nxt = M_CD; end
      M_CD:
        if (tick) begin
          m_frames++;
          if (m_frames == CD_FRAMES) begin nxt = M_PLAY; m_grace = GRACE; end
        end
      M_PLAY:
        if (collision && m_grace == 0) begin nxt = M_HIT; if (m_lives > 0) m_lives--; end
        else if (goal) begin nxt = M_LU; m_level++; end
        else if (tick && m_grace > 0) m_grace--;
      M_HIT:
        if (tick) begin
          m_frames++;
          if (m_frames == HIT_FRAMES) begin
            if (m_lives == 0) nxt = M_GO;
            else begin m_respawn = 1; m_grace = GRACE; nxt = M_PLAY; end
          end
        end
      M_LU:
        if (tick) begin
          m_frames++;
          if (m_frames == HIT_FRAMES) begin
            if (m_level == MAX_LEVEL) nxt = M_WIN;
            else begin
              m_respawn = 1; nxt = M_CD;
`ifdef ROUND_SEQ_LIFE_BONUS_EN
              if (m_lives < START_LIVES) m_lives++;
`endif
            end
          end
        end
      default: nxt = M_IDLE;
    endcase
    if (nxt != m_state) begin m_frames = 0; m_blink = 1; m_bticks = 0; end
    if (abort) begin
      nxt = M_IDLE; m_lives = START_LIVES; m_level = 0; m_frames = 0;
      m_grace = 0; m_blink = 1; m_bticks = 0; m_respawn = 0;
    end
    m_state = nxt;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      model_step();
      m_now = model_tuple();
      if (m_now != m_prev) begin
        exp_q.push_back({32'(cyc), m_now});
        m_prev = m_now;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [TW-1:0] mon_prev = pack(M_IDLE, 1, 0, 0, START_LIVES, 1, 0, 0);
  logic [TW-1:0] obs;
  logic [W-1:0]  front;
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {st, freeze, respawn, level, lives, blink, game_over, win};
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        if (front[W-1:TW] < 32'(cyc)) begin
          vectors++; miscompares++;
          $display("FAIL missed_event cyc=%0d got=no_change exp_cyc=%0d exp=%h",
                   cyc, front[W-1:TW], front[TW-1:0]);
          void'(exp_q.pop_front());
        end
      end
      if (obs != mon_prev) begin
        mon_prev = obs;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cyc=%0d got=%h exp=no_change", cyc, obs);
        end else begin
          front = exp_q.pop_front();
          if (front != {32'(cyc), obs}) begin
            miscompares++;
            $display("FAIL event cyc=%0d got=%h exp_cyc=%0d exp=%h",
                     cyc, obs, front[W-1:TW], front[TW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    if (tick_wait == 0) begin tick = 1'b1; tick_wait = $urandom_range(1, 4); end
    else begin tick = 1'b0; tick_wait--; end
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_model(input int s, input bit need_grace0, input int budget, input string name);
    int n;
    bit ok;
    n = 0;
    ok = (m_state == s) && (!need_grace0 || m_grace == 0);
    while (!ok && n < budget) begin
      next_cycle();
      n++;
      ok = (m_state == s) && (!need_grace0 || m_grace == 0);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL timeout_%s got=state%0d exp=state%0d", name, m_state, s);
    end
  endtask

  task automatic press_start();
    next_cycle(); start = 1'b1;
    next_cycle(); start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_state", st, M_IDLE);
    check("rst_freeze", freeze, 1);
    check("rst_respawn", respawn, 0);
    check("rst_level", level, 0);
    check("rst_lives", lives, START_LIVES);
    check("rst_blink", blink, 1);
    check("rst_flags", {game_over, win}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Game start and countdown.
    press_start();
    check("start_respawn", respawn, 1);
    check("start_state", st, M_CD);
    next_cycle();
    check("respawn_width", respawn, 0);
    wait_model(M_PLAY, 1'b0, 2000, "countdown");
    check("play_state", st, M_PLAY);
    check("play_freeze", freeze, 0);
    check("play_lives", lives, 3);
    check("play_level", level, 0);

    // Collision held: one hit per grace window, down to game over.
    wait_model(M_PLAY, 1'b1, 2000, "grace1");
    collision = 1'b1;
    wait_model(M_HIT, 1'b0, 10, "hit1");
    check("hit1_lives", lives, 2);
    check("hit1_freeze", freeze, 1);
    wait_model(M_PLAY, 1'b0, 2000, "respawn1");
    check("hit1_respawn", respawn, 1);
    wait_model(M_PLAY, 1'b1, 2000, "grace2");
    check("no_hit_in_grace", st, M_PLAY);
    check("grace_lives", lives, 2);
    wait_model(M_GO, 1'b0, 5000, "game_over");
    collision = 1'b0;
    check("go_lives", lives, 0);
    check("go_flag", game_over, 1);
    press_start();
    check("restart_state", st, M_CD);
    check("restart_lives", lives, 3);
    check("restart_respawn", respawn, 1);

    // Goal and collision together: collision wins.
    wait_model(M_PLAY, 1'b1, 3000, "grace3");
    collision = 1'b1; goal = 1'b1;
    next_cycle();
    collision = 1'b0; goal = 1'b0;
    check("tie_state", st, M_HIT);
    check("tie_level", level, 0);
    check("tie_lives", lives, 2);

    // Climb to the winning level.
    wait_model(M_PLAY, 1'b0, 2000, "respawn_tie");
    n = 0;
    while (m_state != M_WIN && n < 20000) begin
      next_cycle();
      goal = (m_state == M_PLAY);
      n++;
    end
    goal = 1'b0;
    check("win_reached", int'(m_state == M_WIN), 1);
    check("win_level", level, MAX_LEVEL);
    check("win_flag", win, 1);
`ifdef ROUND_SEQ_LIFE_BONUS_EN
    check("win_lives", lives, 3);
`else
    check("win_lives", lives, 2);
`endif

    // Abort in the middle of HIT, on a frame tick.
    press_start();
    wait_model(M_PLAY, 1'b0, 2000, "cd_abort");
    next_cycle(); goal = 1'b1;
    next_cycle(); goal = 1'b0;
    wait_model(M_PLAY, 1'b1, 5000, "grace_abort");
    collision = 1'b1;
    next_cycle();
    collision = 1'b0;
    check("pre_abort_state", st, M_HIT);
    check("pre_abort_level", level, 1);
    repeat (5) next_cycle();
    n = 0;
    do begin next_cycle(); n++; end while (!tick && n < 10);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    check("abort_state", st, M_IDLE);
    check("abort_lives", lives, START_LIVES);
    check("abort_level", level, 0);
    check("abort_respawn", respawn, 0);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      if ($urandom_range(0, 29) == 0) start = ~start;
      collision = ($urandom_range(0, 99) < 4);
      goal      = ($urandom_range(0, 149) == 0);
      abort     = ($urandom_range(0, 799) == 0);
    end
    start = 1'b0; collision = 1'b0; goal = 1'b0; abort = 1'b0;
    repeat (5) next_cycle();
    check("queue_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
